// File: rtl/jtag_cmd_bridge.sv
// jtag_cmd_bridge
// Turns JTAG register-update commands (jtck domain) into a byte-stream UART
// channel plus break/reset requests in the CPU clock domain, and returns the
// TX holding byte and status to the host.
//
// Command codes on reg_addr_q:
//   0 NOP | 1 RX_WRITE | 2 TX_ACK | 3 BREAK | 4 RESET | 5 CLEAR | 6-7 ignored
module jtag_cmd_bridge #(
    parameter int RX_DEPTH_LOG2 = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       reg_update,
    input  logic [7:0] reg_q,
    input  logic [2:0] reg_addr_q,
    output logic [7:0] reg_d,
    output logic [2:0] reg_addr_d,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       break_o,
    output logic       reset_o,
    output logic       overflow_o
);

    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;

    localparam logic [2:0] CMD_RX_WRITE = 3'd1;
    localparam logic [2:0] CMD_TX_ACK   = 3'd2;
    localparam logic [2:0] CMD_BREAK    = 3'd3;
    localparam logic [2:0] CMD_RESET    = 3'd4;
    localparam logic [2:0] CMD_CLEAR    = 3'd5;

    localparam logic [RX_DEPTH_LOG2:0] PTR_ONE = {{RX_DEPTH_LOG2{1'b0}}, 1'b1};

    // Synchronizer flops (reset to 1 so a strobe held across reset is not a command)
    logic r_s1, r_s2, r_s3;

    // RX FIFO storage and pointers (one extra wrap bit)
    logic [7:0]             r_mem [RX_DEPTH];
    logic [RX_DEPTH_LOG2:0] r_wr_ptr;
    logic [RX_DEPTH_LOG2:0] r_rd_ptr;

    logic       r_tx_full;
    logic [7:0] r_tx_data;
    logic       r_overflow;
    logic       r_break;
    logic       r_reset;
    logic [7:0] r_reg_d;
    logic [2:0] r_reg_addr_d;

    logic w_cmd;
    logic w_cmd_rx_write;
    logic w_cmd_tx_ack;
    logic w_cmd_break;
    logic w_cmd_reset;
    logic w_cmd_clear;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_tx_load;

    // Rising edge of the synchronized strobe; payload is quasi-static so it is used directly
    assign w_cmd          = r_s2 & ~r_s3;
    assign w_cmd_rx_write = w_cmd & (reg_addr_q == CMD_RX_WRITE);
    assign w_cmd_tx_ack   = w_cmd & (reg_addr_q == CMD_TX_ACK);
    assign w_cmd_break    = w_cmd & (reg_addr_q == CMD_BREAK);
    assign w_cmd_reset    = w_cmd & (reg_addr_q == CMD_RESET);
    assign w_cmd_clear    = w_cmd & (reg_addr_q == CMD_CLEAR);

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[RX_DEPTH_LOG2] != r_rd_ptr[RX_DEPTH_LOG2]) &&
                     (r_wr_ptr[RX_DEPTH_LOG2-1:0] == r_rd_ptr[RX_DEPTH_LOG2-1:0]);

    // A pop frees the slot in the same cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign w_pop  = ~w_empty & rx_ready;
    assign w_push = w_cmd_rx_write & (~w_full | w_pop);
    assign w_drop = w_cmd_rx_write & w_full & ~w_pop;

    assign w_tx_load = tx_valid & ~r_tx_full;

    assign rx_valid   = ~w_empty;
    assign rx_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr[RX_DEPTH_LOG2-1:0]];
    assign tx_ready   = ~r_tx_full;
    assign break_o    = r_break;
    assign reset_o    = r_reset;
    assign overflow_o = r_overflow;
    assign reg_d      = r_reg_d;
    assign reg_addr_d = r_reg_addr_d;

    // Three-flop synchronizer for the jtck-domain update strobe
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= reg_update;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // FIFO storage write; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[RX_DEPTH_LOG2-1:0]] <= reg_q;
        end
    end

    // FIFO pointer update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // TX holding register: CPU load when empty, host ACK clears
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_full <= 1'b0;
            r_tx_data <= 8'h00;
        end else if (w_cmd_tx_ack && r_tx_full) begin
            r_tx_full <= 1'b0;
        end else if (w_tx_load) begin
            r_tx_full <= 1'b1;
            r_tx_data <= tx_data;
        end
    end

    // Sticky overflow; a drop in the same cycle as CLEAR keeps it set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_cmd_clear) begin
            r_overflow <= 1'b0;
        end
    end

    // Single-cycle break and reset request pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_break <= 1'b0;
            r_reset <= 1'b0;
        end else begin
            r_break <= w_cmd_break;
            r_reset <= w_cmd_reset;
        end
    end

    // Host read-back registers, one cycle behind the state they report
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_reg_d      <= 8'h00;
            r_reg_addr_d <= 3'b000;
        end else begin
            r_reg_d      <= r_tx_full ? r_tx_data : 8'h00;
            r_reg_addr_d <= {r_overflow, w_full, r_tx_full};
        end
    end

endmodule

// File: tb/tb_jtag_cmd_bridge.sv
// Directed bench for jtag_cmd_bridge: host commands, RX FIFO, TX holding
// register, break/reset pulses and reset behaviour.
module tb_jtag_cmd_bridge;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       reg_update;
    logic [7:0] reg_q;
    logic [2:0] reg_addr_q;
    logic [7:0] reg_d;
    logic [2:0] reg_addr_d;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       break_o;
    logic       reset_o;
    logic       overflow_o;

    int total = 0;
    int bad   = 0;
    int brk_hi = 0;
    int rst_hi = 0;

    jtag_cmd_bridge #(.RX_DEPTH_LOG2(2)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .reg_update (reg_update),
        .reg_q      (reg_q),
        .reg_addr_q (reg_addr_q),
        .reg_d      (reg_d),
        .reg_addr_d (reg_addr_d),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .break_o    (break_o),
        .reset_o    (reset_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Count high cycles of the request pulses, sampled mid-cycle
    always @(negedge clk_i) begin
        if (break_o === 1'b1) brk_hi <= brk_hi + 1;
        if (reset_o === 1'b1) rst_hi <= rst_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one host command; returns after it has taken effect and status is updated
    task automatic host_cmd(input logic [2:0] addr, input logic [7:0] q, input int hold);
        reg_addr_q = addr;
        reg_q      = q;
        reg_update = 1'b1;
        repeat (hold) @(negedge clk_i);
        reg_update = 1'b0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        @(negedge clk_i);
        rx_ready = 1'b0;
    endtask

    initial begin
        int b0;
        int r0;
        rst_i      = 1'b1;
        reg_update = 1'b0;
        reg_q      = 8'h00;
        reg_addr_q = 3'd0;
        rx_ready   = 1'b0;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        repeat (3) @(negedge clk_i);

        // Reset values
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_reg_d", {24'd0, reg_d}, 32'h00);
        check("rst_reg_addr_d", {29'd0, reg_addr_d}, 32'd0);
        check("rst_break", {31'd0, break_o}, 32'd0);
        check("rst_reset", {31'd0, reset_o}, 32'd0);
        check("rst_overflow", {31'd0, overflow_o}, 32'd0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Single RX_WRITE with edge-accurate latency
        reg_addr_q = 3'd1;
        reg_q      = 8'hA5;
        reg_update = 1'b1;
        @(negedge clk_i);
        check("lat_e1_valid", {31'd0, rx_valid}, 32'd0);
        @(negedge clk_i);
        check("lat_e2_valid", {31'd0, rx_valid}, 32'd0);
        @(negedge clk_i);
        check("lat_e3_valid", {31'd0, rx_valid}, 32'd1);
        check("lat_e3_data", {24'd0, rx_data}, 32'hA5);
        reg_update = 1'b0;
        @(negedge clk_i);
        check("lat_e4_status", {29'd0, reg_addr_d}, 32'd0);
        rx_ready = 1'b1;
        @(negedge clk_i);
        rx_ready = 1'b0;
        check("pop_empty", {31'd0, rx_valid}, 32'd0);
        repeat (3) @(negedge clk_i);

        // Five writes into a four-entry FIFO: fifth dropped, overflow set
        for (int i = 1; i <= 4; i++) host_cmd(3'd1, 8'(i), 3);
        check("fill4_status", {29'd0, reg_addr_d}, 32'b010);
        check("fill4_ovf", {31'd0, overflow_o}, 32'd0);
        host_cmd(3'd1, 8'h05, 3);
        check("ovf_status", {29'd0, reg_addr_d}, 32'b110);
        check("ovf_flag", {31'd0, overflow_o}, 32'd1);
        pop_expect("drain1", 8'h01);
        pop_expect("drain2", 8'h02);
        pop_expect("drain3", 8'h03);
        pop_expect("drain4", 8'h04);
        check("drain_empty", {31'd0, rx_valid}, 32'd0);
        host_cmd(3'd5, 8'h00, 3);
        check("clear_ovf", {31'd0, overflow_o}, 32'd0);
        check("clear_status", {29'd0, reg_addr_d}, 32'b000);

        // Push into a full FIFO on the same edge as a pop
        for (int i = 0; i < 4; i++) host_cmd(3'd1, 8'(8'h11 + i), 3);
        reg_addr_q = 3'd1;
        reg_q      = 8'h77;
        reg_update = 1'b1;
        repeat (2) @(negedge clk_i);
        rx_ready = 1'b1;
        @(negedge clk_i);
        rx_ready   = 1'b0;
        reg_update = 1'b0;
        repeat (3) @(negedge clk_i);
        check("pp_ovf", {31'd0, overflow_o}, 32'd0);
        check("pp_status", {29'd0, reg_addr_d}, 32'b010);
        pop_expect("pp1", 8'h12);
        pop_expect("pp2", 8'h13);
        pop_expect("pp3", 8'h14);
        pop_expect("pp4", 8'h77);
        check("pp_empty", {31'd0, rx_valid}, 32'd0);

        // TX holding register
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk_i);
        tx_data = 8'h5A;
        check("tx_ready_low", {31'd0, tx_ready}, 32'd0);
        @(negedge clk_i);
        check("tx_reg_d", {24'd0, reg_d}, 32'h3C);
        check("tx_status", {29'd0, reg_addr_d}, 32'b001);
        repeat (3) @(negedge clk_i);
        check("tx_stall_reg_d", {24'd0, reg_d}, 32'h3C);
        check("tx_stall_ready", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
        host_cmd(3'd2, 8'h00, 3);
        check("ack_ready", {31'd0, tx_ready}, 32'd1);
        check("ack_reg_d", {24'd0, reg_d}, 32'h00);
        check("ack_status", {29'd0, reg_addr_d}, 32'b000);

        // Long-held strobes: one pulse per command
        b0 = brk_hi; r0 = rst_hi;
        host_cmd(3'd3, 8'h00, 20);
        check("brk_pulse", 32'(brk_hi - b0), 32'd1);
        check("brk_no_rst", 32'(rst_hi - r0), 32'd0);
        b0 = brk_hi; r0 = rst_hi;
        host_cmd(3'd4, 8'h00, 20);
        check("rst_pulse", 32'(rst_hi - r0), 32'd1);
        check("rst_no_brk", 32'(brk_hi - b0), 32'd0);
        b0 = brk_hi; r0 = rst_hi;
        host_cmd(3'd7, 8'hFF, 20);
        check("a7_no_pulse", 32'(brk_hi - b0 + rst_hi - r0), 32'd0);
        check("a7_status", {29'd0, reg_addr_d}, 32'b000);
        check("a7_rx", {31'd0, rx_valid}, 32'd0);

        // Reset with strobe high across it; FIFO contents discarded
        host_cmd(3'd1, 8'h99, 3);
        check("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
        b0 = brk_hi; r0 = rst_hi;
        reg_addr_q = 3'd1;
        reg_q      = 8'hEE;
        reg_update = 1'b1;
        rst_i      = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (6) @(negedge clk_i);
        check("rsthi_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rsthi_status", {29'd0, reg_addr_d}, 32'b000);
        check("rsthi_reg_d", {24'd0, reg_d}, 32'h00);
        check("rsthi_ovf", {31'd0, overflow_o}, 32'd0);
        reg_update = 1'b0;
        repeat (4) @(negedge clk_i);
        host_cmd(3'd1, 8'h5B, 3);
        check("post_rst_valid", {31'd0, rx_valid}, 32'd1);
        check("post_rst_data", {24'd0, rx_data}, 32'h5B);
        check("rsthi_no_pulse", 32'(brk_hi - b0 + rst_hi - r0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
